mesi_coherence_ctrl: RTL and testbench
======================================

// Module: mesi_coherence_ctrl
// PURPOSE
//  Multi-line MESI coherence controller for one private cache. Holds a MESI state per line.
//  Serves processor requests through a valid/ready handshake and arbitrates for the shared bus
//  with req/gnt. Snoops other caches' bus commands and flushes dirty lines over a multi-beat window.
//  Sits between the cache tag/data array and the shared snooping bus.
// PARAMETERS
//  NUM_LINES     16                   number of tracked cache lines
//  IDX_W         $clog2(NUM_LINES)    line index width
//  FLUSH_BEATS   4                    cycles snp_flush stays high per dirty-line writeback (>=1)
//  MSI_MODE      0                    1 = E state disabled; read misses always fill to S
// PORTS
//  clk            in   1      clock
//  rstb           in   1      asynchronous active-low reset
//  pr_valid       in   1      processor request valid; held until pr_ready
//  pr_we          in   1      1 = write (PrWr), 0 = read (PrRd)
//  pr_idx         in   IDX_W  line addressed by processor
//  pr_ready       out  1      one-cycle pulse: request complete
//  bus_req        out  1      bus request to arbiter
//  bus_gnt        in   1      arbiter grant, valid only while bus_req is high
//  bus_cmd        out  2      bus_cmd_t issued in the grant cycle; NONE otherwise
//  bus_idx        out  IDX_W  line index of bus_cmd
//  bus_shared_in  in   1      another cache holds the line; sampled in the grant cycle
//  snp_valid      in   1      snooped command from another cache
//  snp_cmd        in   2      snooped bus_cmd_t
//  snp_idx        in   IDX_W  snooped line index
//  snp_ready      out  1      snoop accepted this cycle; low during FLUSH
//  snp_shared_out out  1      combinational: snp RD or RDX hits a line in S, E or M
//  snp_flush      out  1      high for FLUSH_BEATS cycles while the dirty line is written back
//  dbg_idx        in   IDX_W  debug read index
//  dbg_state      out  2      combinational MESI state of line dbg_idx
// BEHAVIOUR
//  Reset: all lines I, FSM IDLE. pr_ready, bus_req, snp_flush and snp_shared_out are 0.
//   bus_cmd=NONE, bus_idx=0, snp_ready=1. Reset mid-operation aborts any transaction and flush silently.
//  FSM states: IDLE, BUS_REQ, FLUSH.
//  IDLE, snoop accepted (snp_valid & snp_ready):
//   - M on RD -> S via FLUSH; M on RDX -> I via FLUSH.
//   - E on RD -> S; E on RDX -> I.
//   - S on RDX or UPGR -> I.
//   - All other combinations: no change.
//  Snoop has priority. When snp_valid and pr_valid arrive together, the snoop is applied first.
//   The processor request is evaluated the following cycle against the updated state.
//  IDLE, processor request with no snoop:
//   - Hits: M rd/wr; E rd; E wr (silent E->M); S rd. State is updated at the edge.
//     pr_ready is high the next cycle (latency 1).
//   - Misses: I rd -> RD; I wr -> RDX; S wr -> UPGR. FSM moves to BUS_REQ.
//  BUS_REQ:
//   - bus_req stays high until bus_gnt; it is never withdrawn early.
//   - In the grant cycle, drive bus_cmd/bus_idx and sample bus_shared_in.
//   - Final state: RD -> S if shared or MSI_MODE, else E. RDX -> M. UPGR -> M.
//   - At the grant edge: bus_req drops, FSM returns to IDLE, pr_ready is high for the next cycle.
//  Snoops stay accepted in BUS_REQ:
//   - A snoop to the pending line that moves it S->I before grant converts the pending UPGR to RDX.
//   - A snoop in the grant cycle itself is applied before the bus fill.
//  FLUSH:
//   - snp_flush is high for exactly FLUSH_BEATS cycles starting the cycle after acceptance.
//   - snp_ready=0 throughout FLUSH. The line's final state is written on the last beat.
//   - FSM then returns to its prior state (IDLE or BUS_REQ). bus_req is held if it was high.
//  A snoop that hits a line in I is a no-op.
//  snp_cmd=NONE with snp_valid is a no-op.
//  Out-of-range idx is not possible for power-of-2 NUM_LINES. Otherwise it is treated as a miss with no state write.
// STRUCTURE
//  mesi_pkg: mesi_t enum {I=2'b00,S=2'b01,E=2'b10,M=2'b11}; bus_cmd_t {NONE,RD,RDX,UPGR}.
//   mesi_pkg also holds the function is_valid(mesi_t).
//  Sub-module mesi_line_next: pure combinational transition function.
//   Inputs: mesi_t, event kind, shared, MSI_MODE. Outputs: next state, bus_cmd, flush_needed.
//  Top level: state array (NUM_LINES x mesi_t flops), control FSM, flush beat counter, pending-request registers.
// TESTING
//  1 Reset, then read idx 3 with shared_in=0 and gnt after 2 cycles.
//    -> bus_cmd=RD for 1 cycle, line 3 = E, pr_ready 1 cycle after grant.
//  2 Line 5 in E, write idx 5.
//    -> no bus_req, line 5 = M, pr_ready 1 cycle later.
//  3 Line 7 in M, snoop RD idx 7.
//    -> snp_shared_out=1, snp_flush high 4 cycles, snp_ready=0 for 4 cycles, line 7 = S.
//  4 Line 2 in S, write idx 2, gnt held off, then snoop UPGR idx 2.
//    -> line 2 = I, bus_cmd at grant = RDX (not UPGR), line 2 = M.
//  5 snp_valid and pr_valid in the same cycle on idx 1 (M): snoop RDX then processor read.
//    -> flush 4 beats, line 1 = I, then bus_cmd=RD, pr_ready after grant.
//  6 MSI_MODE=1, read miss idx 0 with shared_in=0 -> line 0 = S.
//    Reset asserted mid-FLUSH -> all outputs at reset values, all lines I.

Source files
------------

// File: rtl/mesi_pkg.sv
// MESI coherence shared types: line states, bus commands,
// transition event kinds and control FSM states.
package mesi_pkg;

   typedef enum logic [1:0] {
      I = 2'b00,
      S = 2'b01,
      E = 2'b10,
      M = 2'b11
   } mesi_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      RD   = 2'd1,
      RDX  = 2'd2,
      UPGR = 2'd3
   } bus_cmd_t;

   typedef enum logic [2:0] {
      EV_NONE,
      EV_PR_RD,
      EV_PR_WR,
      EV_SNP_RD,
      EV_SNP_RDX,
      EV_SNP_UPGR,
      EV_FILL_RD,
      EV_FILL_RDX
   } ev_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS_REQ,
      ST_FLUSH
   } fsm_t;

   function automatic logic is_valid(input mesi_t s);
      return s != I;
   endfunction

endpackage

// File: rtl/mesi_line_next.sv
// Pure MESI transition function for a single line: next state,
// bus command needed to complete the event, and dirty-flush flag.
module mesi_line_next
   import mesi_pkg::*;
(
   input  mesi_t    i_cur,
   input  ev_t      i_ev,
   input  logic     i_shared,
   input  logic     i_msi,
   output mesi_t    o_nxt,
   output bus_cmd_t o_cmd,
   output logic     o_flush
);

   always_comb begin
      o_nxt   = i_cur;
      o_cmd   = NONE;
      o_flush = 1'b0;
      case (i_ev)
         EV_PR_RD: begin
            if (i_cur == I) o_cmd = RD;
         end
         EV_PR_WR: begin
            case (i_cur)
               I:       o_cmd = RDX;
               S:       o_cmd = UPGR;
               default: o_nxt = M;
            endcase
         end
         EV_SNP_RD: begin
            if (i_cur == M || i_cur == E) o_nxt = S;
            o_flush = (i_cur == M);
         end
         EV_SNP_RDX: begin
            o_nxt   = I;
            o_flush = (i_cur == M);
         end
         EV_SNP_UPGR: begin
            if (i_cur == S) o_nxt = I;
         end
         EV_FILL_RD:  o_nxt = (i_shared || i_msi) ? S : E;
         EV_FILL_RDX: o_nxt = M;
         default: ;
      endcase
   end

endmodule

// File: rtl/mesi_coherence_ctrl.sv
// MESI controller for one private cache: per-line state array,
// bus request/grant sequencing and multi-beat snoop writeback.
module mesi_coherence_ctrl
   import mesi_pkg::*;
#(
   parameter int NUM_LINES   = 16,
   parameter int IDX_W       = $clog2(NUM_LINES),
   parameter int FLUSH_BEATS = 4,
   parameter bit MSI_MODE    = 1'b0
)(
   input  logic             clk,
   input  logic             rstb,
   input  logic             pr_valid,
   input  logic             pr_we,
   input  logic [IDX_W-1:0] pr_idx,
   output logic             pr_ready,
   output logic             bus_req,
   input  logic             bus_gnt,
   output bus_cmd_t         bus_cmd,
   output logic [IDX_W-1:0] bus_idx,
   input  logic             bus_shared_in,
   input  logic             snp_valid,
   input  bus_cmd_t         snp_cmd,
   input  logic [IDX_W-1:0] snp_idx,
   output logic             snp_ready,
   output logic             snp_shared_out,
   output logic             snp_flush,
   input  logic [IDX_W-1:0] dbg_idx,
   output mesi_t            dbg_state
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int BW = $clog2(FLUSH_BEATS + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(FLUSH_BEATS - 1);
   localparam logic [DEPTH-1:0] LINE_OK =
      {DEPTH{1'b1}} >> (DEPTH - NUM_LINES);

   mesi_t            r_lines [NUM_LINES];
   fsm_t             r_state, w_nstate;
   fsm_t             r_ret, w_nret;
   logic [BW-1:0]    r_beat, w_nbeat;
   logic [IDX_W-1:0] r_fl_idx, w_nfl_idx;
   mesi_t            r_fl_val, w_nfl_val;
   logic [IDX_W-1:0] r_pend_idx, w_npend_idx;
   bus_cmd_t         r_pend_cmd, w_npend_cmd;
   logic             r_pr_ready, w_npr_ready;

   logic             w_wa_en, w_wb_en;
   logic [IDX_W-1:0] w_wa_idx;
   mesi_t            w_wa_val;

   mesi_t            w_snp_line, w_snp_nxt, w_pr_line, w_pr_nxt;
   mesi_t            w_fill_nxt;
   ev_t              w_snp_ev, w_pr_ev, w_fill_ev;
   bus_cmd_t         w_pr_cmd, w_cmd;
   bus_cmd_t         w_snp_cmd_nc, w_fill_cmd_nc;
   logic             w_snp_fl, w_pr_fl_nc, w_fill_fl_nc;
   logic             w_snp_acc, w_pr_acc, w_gnt, w_pend_kill;
   logic             w_unused;

   // Out-of-range indices read as I so they always miss.
   function automatic mesi_t rd_line(input logic [IDX_W-1:0] i);
      return LINE_OK[i] ? r_lines[i] : I;
   endfunction

   assign w_snp_line = rd_line(snp_idx);
   assign w_pr_line  = rd_line(pr_idx);
   assign dbg_state  = rd_line(dbg_idx);

   always_comb begin
      case (snp_cmd)
         RD:      w_snp_ev = EV_SNP_RD;
         RDX:     w_snp_ev = EV_SNP_RDX;
         UPGR:    w_snp_ev = EV_SNP_UPGR;
         default: w_snp_ev = EV_NONE;
      endcase
   end

   assign w_pr_ev   = pr_we ? EV_PR_WR : EV_PR_RD;
   assign w_fill_ev = (w_cmd == RD) ? EV_FILL_RD : EV_FILL_RDX;

   mesi_line_next u_snp (
      .i_cur(w_snp_line), .i_ev(w_snp_ev), .i_shared(1'b0),
      .i_msi(MSI_MODE), .o_nxt(w_snp_nxt), .o_cmd(w_snp_cmd_nc),
      .o_flush(w_snp_fl));

   mesi_line_next u_pr (
      .i_cur(w_pr_line), .i_ev(w_pr_ev), .i_shared(1'b0),
      .i_msi(MSI_MODE), .o_nxt(w_pr_nxt), .o_cmd(w_pr_cmd),
      .o_flush(w_pr_fl_nc));

   mesi_line_next u_fill (
      .i_cur(I), .i_ev(w_fill_ev), .i_shared(bus_shared_in),
      .i_msi(MSI_MODE), .o_nxt(w_fill_nxt), .o_cmd(w_fill_cmd_nc),
      .o_flush(w_fill_fl_nc));

   assign w_unused = ^{w_snp_cmd_nc, w_fill_cmd_nc,
                       w_pr_fl_nc, w_fill_fl_nc};

   assign snp_ready = (r_state != ST_FLUSH);
   assign snp_flush = (r_state == ST_FLUSH);
   assign bus_req   = (r_state == ST_BUS_REQ) ||
                      (r_state == ST_FLUSH && r_ret == ST_BUS_REQ);
   assign pr_ready  = r_pr_ready;

   assign w_snp_acc = snp_valid && snp_ready;
   assign w_gnt     = bus_req && bus_gnt;
   assign w_pr_acc  = (r_state == ST_IDLE) && pr_valid &&
                      !snp_valid && !r_pr_ready;

   assign snp_shared_out = snp_valid && is_valid(w_snp_line) &&
                           (snp_cmd == RD || snp_cmd == RDX);

   // Losing S on the pending line before grant needs a full RDX.
   assign w_pend_kill = w_snp_acc && bus_req &&
                        snp_idx == r_pend_idx &&
                        r_pend_cmd == UPGR && w_snp_nxt == I;
   assign w_cmd   = w_pend_kill ? RDX : r_pend_cmd;
   assign bus_cmd = w_gnt ? w_cmd : NONE;
   assign bus_idx = w_gnt ? r_pend_idx : '0;

   always_comb begin
      w_nstate    = r_state;
      w_nret      = r_ret;
      w_nbeat     = r_beat;
      w_nfl_idx   = r_fl_idx;
      w_nfl_val   = r_fl_val;
      w_npend_idx = r_pend_idx;
      w_npend_cmd = w_cmd;
      w_npr_ready = w_gnt;
      w_wa_en     = 1'b0;
      w_wa_idx    = snp_idx;
      w_wa_val    = w_snp_nxt;
      w_wb_en     = w_gnt;
      case (r_state)
         ST_IDLE, ST_BUS_REQ: begin
            if (w_gnt) w_nstate = ST_IDLE;
            if (w_snp_acc) begin
               if (w_snp_fl) begin
                  w_nret    = w_nstate;
                  w_nstate  = ST_FLUSH;
                  w_nbeat   = LAST_BEAT;
                  w_nfl_idx = snp_idx;
                  w_nfl_val = w_snp_nxt;
               end else begin
                  w_wa_en = 1'b1;
               end
            end else if (w_pr_acc) begin
               if (w_pr_cmd == NONE) begin
                  w_wa_en     = 1'b1;
                  w_wa_idx    = pr_idx;
                  w_wa_val    = w_pr_nxt;
                  w_npr_ready = 1'b1;
               end else begin
                  w_npend_cmd = w_pr_cmd;
                  w_npend_idx = pr_idx;
                  w_nstate    = ST_BUS_REQ;
               end
            end
         end
         ST_FLUSH: begin
            if (w_gnt) w_nret = ST_IDLE;
            if (r_beat == '0) begin
               w_wa_en  = 1'b1;
               w_wa_idx = r_fl_idx;
               w_wa_val = r_fl_val;
               w_nstate = w_nret;
            end else begin
               w_nbeat = r_beat - 1'b1;
            end
         end
         default: w_nstate = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state    <= ST_IDLE;
         r_ret      <= ST_IDLE;
         r_beat     <= '0;
         r_fl_idx   <= '0;
         r_fl_val   <= I;
         r_pend_idx <= '0;
         r_pend_cmd <= NONE;
         r_pr_ready <= 1'b0;
      end else begin
         r_state    <= w_nstate;
         r_ret      <= w_nret;
         r_beat     <= w_nbeat;
         r_fl_idx   <= w_nfl_idx;
         r_fl_val   <= w_nfl_val;
         r_pend_idx <= w_npend_idx;
         r_pend_cmd <= w_npend_cmd;
         r_pr_ready <= w_npr_ready;
      end
   end

   // Fill is written after the snoop update so it wins on a shared index.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int k = 0; k < NUM_LINES; k++) r_lines[k] <= I;
      end else begin
         if (w_wa_en && LINE_OK[w_wa_idx])
            r_lines[w_wa_idx] <= w_wa_val;
         if (w_wb_en && LINE_OK[r_pend_idx])
            r_lines[r_pend_idx] <= w_fill_nxt;
      end
   end

endmodule

// File: tb/tb_mesi_coherence_ctrl.sv
// Directed bench for mesi_coherence_ctrl: per-cycle vector table
// plus hand sequences for MSI fill and reset during writeback.
module tb_mesi_coherence_ctrl;
   import mesi_pkg::*;

   logic       clk = 1'b0;
   logic       rstb;
   logic       pr_valid, pr_we, bus_gnt, bus_shared_in, snp_valid;
   logic [3:0] pr_idx, snp_idx, dbg_idx;
   bus_cmd_t   snp_cmd;

   logic       pr_ready, bus_req, snp_ready, snp_shared_out, snp_flush;
   bus_cmd_t   bus_cmd;
   logic [3:0] bus_idx;
   mesi_t      dbg_state;

   logic       m_pr_ready, m_bus_req, m_snp_ready, m_sso, m_flush;
   bus_cmd_t   m_bus_cmd;
   logic [3:0] m_bus_idx;
   mesi_t      m_dbg_state;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mesi_coherence_ctrl u_dut (
      .clk(clk), .rstb(rstb),
      .pr_valid(pr_valid), .pr_we(pr_we), .pr_idx(pr_idx),
      .pr_ready(pr_ready), .bus_req(bus_req), .bus_gnt(bus_gnt),
      .bus_cmd(bus_cmd), .bus_idx(bus_idx),
      .bus_shared_in(bus_shared_in),
      .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_idx(snp_idx),
      .snp_ready(snp_ready), .snp_shared_out(snp_shared_out),
      .snp_flush(snp_flush), .dbg_idx(dbg_idx),
      .dbg_state(dbg_state));

   mesi_coherence_ctrl #(.MSI_MODE(1'b1)) u_msi (
      .clk(clk), .rstb(rstb),
      .pr_valid(pr_valid), .pr_we(pr_we), .pr_idx(pr_idx),
      .pr_ready(m_pr_ready), .bus_req(m_bus_req), .bus_gnt(bus_gnt),
      .bus_cmd(m_bus_cmd), .bus_idx(m_bus_idx),
      .bus_shared_in(bus_shared_in),
      .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_idx(snp_idx),
      .snp_ready(m_snp_ready), .snp_shared_out(m_sso),
      .snp_flush(m_flush), .dbg_idx(dbg_idx),
      .dbg_state(m_dbg_state));

   typedef struct {
      logic pv; logic we; logic [3:0] pi;
      logic gnt; logic sh; logic sv; bus_cmd_t sc;
      logic [3:0] si; logic [3:0] di;
      logic rdy; logic req; bus_cmd_t cmd; logic [3:0] bi;
      logic sr; logic sso; logic fl; mesi_t dst;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic pv, input logic we, input logic [3:0] pi,
      input logic gnt, input logic sh, input logic sv,
      input bus_cmd_t sc, input logic [3:0] si, input logic [3:0] di,
      input logic rdy, input logic req, input bus_cmd_t cmd,
      input logic [3:0] bi, input logic sr, input logic sso,
      input logic fl, input mesi_t dst);
      vec_t v;
      v.pv = pv; v.we = we; v.pi = pi; v.gnt = gnt; v.sh = sh;
      v.sv = sv; v.sc = sc; v.si = si; v.di = di;
      v.rdy = rdy; v.req = req; v.cmd = cmd; v.bi = bi;
      v.sr = sr; v.sso = sso; v.fl = fl; v.dst = dst;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      pr_valid = 0; pr_we = 0; pr_idx = 0; bus_gnt = 0;
      bus_shared_in = 0; snp_valid = 0; snp_cmd = NONE;
      snp_idx = 0; dbg_idx = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " pr_ready"}, pr_ready, 0);
      chk({tag, " bus_req"}, bus_req, 0);
      chk({tag, " bus_cmd"}, bus_cmd, NONE);
      chk({tag, " bus_idx"}, bus_idx, 0);
      chk({tag, " snp_ready"}, snp_ready, 1);
      chk({tag, " snp_shared"}, snp_shared_out, 0);
      chk({tag, " snp_flush"}, snp_flush, 0);
   endtask

   initial begin
      // test 1: read miss idx 3, grant two cycles later
      vq.push_back(mk(1,0,3,0,0,0,NONE,0,3, 0,0,NONE,0,1,0,0,I));
      for (int k = 0; k < 2; k++)
         vq.push_back(mk(1,0,3,0,0,0,NONE,0,3, 0,1,NONE,0,1,0,0,I));
      vq.push_back(mk(1,0,3,1,0,0,NONE,0,3, 0,1,RD,3,1,0,0,I));
      vq.push_back(mk(1,0,3,0,0,0,NONE,0,3, 1,0,NONE,0,1,0,0,E));
      // test 2: fill 5 to E, then silent write E->M
      vq.push_back(mk(1,0,5,0,0,0,NONE,0,5, 0,0,NONE,0,1,0,0,I));
      vq.push_back(mk(1,0,5,1,0,0,NONE,0,5, 0,1,RD,5,1,0,0,I));
      vq.push_back(mk(1,0,5,0,0,0,NONE,0,5, 1,0,NONE,0,1,0,0,E));
      vq.push_back(mk(1,1,5,0,0,0,NONE,0,5, 0,0,NONE,0,1,0,0,E));
      vq.push_back(mk(1,1,5,0,0,0,NONE,0,5, 1,0,NONE,0,1,0,0,M));
      // test 3: 7 to M by RDX, then snoop RD flushes 4 beats
      vq.push_back(mk(1,1,7,0,0,0,NONE,0,7, 0,0,NONE,0,1,0,0,I));
      vq.push_back(mk(1,1,7,1,0,0,NONE,0,7, 0,1,RDX,7,1,0,0,I));
      vq.push_back(mk(1,1,7,0,0,0,NONE,0,7, 1,0,NONE,0,1,0,0,M));
      vq.push_back(mk(0,0,0,0,0,1,RD,7,7, 0,0,NONE,0,1,1,0,M));
      for (int k = 0; k < 4; k++)
         vq.push_back(mk(0,0,0,0,0,0,NONE,0,7, 0,0,NONE,0,0,0,1,M));
      vq.push_back(mk(0,0,0,0,0,0,NONE,0,7, 0,0,NONE,0,1,0,0,S));
      // test 4: 2 to S, UPGR pending, snoop UPGR turns it into RDX
      vq.push_back(mk(1,0,2,0,0,0,NONE,0,2, 0,0,NONE,0,1,0,0,I));
      vq.push_back(mk(1,0,2,1,1,0,NONE,0,2, 0,1,RD,2,1,0,0,I));
      vq.push_back(mk(1,0,2,0,0,0,NONE,0,2, 1,0,NONE,0,1,0,0,S));
      vq.push_back(mk(1,1,2,0,0,0,NONE,0,2, 0,0,NONE,0,1,0,0,S));
      vq.push_back(mk(1,1,2,0,0,0,NONE,0,2, 0,1,NONE,0,1,0,0,S));
      vq.push_back(mk(1,1,2,0,0,1,UPGR,2,2, 0,1,NONE,0,1,0,0,S));
      vq.push_back(mk(1,1,2,1,0,0,NONE,0,2, 0,1,RDX,2,1,0,0,I));
      vq.push_back(mk(1,1,2,0,0,0,NONE,0,2, 1,0,NONE,0,1,0,0,M));
      // test 5: 1 to M; snoop RDX and read together
      vq.push_back(mk(1,1,1,0,0,0,NONE,0,1, 0,0,NONE,0,1,0,0,I));
      vq.push_back(mk(1,1,1,1,0,0,NONE,0,1, 0,1,RDX,1,1,0,0,I));
      vq.push_back(mk(1,1,1,0,0,0,NONE,0,1, 1,0,NONE,0,1,0,0,M));
      vq.push_back(mk(1,0,1,0,0,1,RDX,1,1, 0,0,NONE,0,1,1,0,M));
      for (int k = 0; k < 4; k++)
         vq.push_back(mk(1,0,1,0,0,0,NONE,0,1, 0,0,NONE,0,0,0,1,M));
      vq.push_back(mk(1,0,1,0,0,0,NONE,0,1, 0,0,NONE,0,1,0,0,I));
      vq.push_back(mk(1,0,1,0,0,0,NONE,0,1, 0,1,NONE,0,1,0,0,I));
      vq.push_back(mk(1,0,1,1,0,0,NONE,0,1, 0,1,RD,1,1,0,0,I));
      vq.push_back(mk(1,0,1,0,0,0,NONE,0,1, 1,0,NONE,0,1,0,0,E));
      vq.push_back(mk(0,0,0,0,0,0,NONE,0,1, 0,0,NONE,0,1,0,0,E));
      // snoop RD on E, NONE no-op, RDX to an I line
      vq.push_back(mk(0,0,0,0,0,1,RD,3,3, 0,0,NONE,0,1,1,0,E));
      vq.push_back(mk(0,0,0,0,0,1,NONE,3,3, 0,0,NONE,0,1,0,0,S));
      vq.push_back(mk(0,0,0,0,0,1,RDX,9,9, 0,0,NONE,0,1,0,0,I));
      vq.push_back(mk(0,0,0,0,0,0,NONE,0,3, 0,0,NONE,0,1,0,0,S));

      idle_in();
      rstb = 0;
      #12;
      chk_reset("reset");
      chk("reset line0", dbg_state, I);
      @(negedge clk);
      rstb = 1;

      foreach (vq[i]) begin
         @(negedge clk);
         pr_valid = vq[i].pv; pr_we = vq[i].we; pr_idx = vq[i].pi;
         bus_gnt = vq[i].gnt; bus_shared_in = vq[i].sh;
         snp_valid = vq[i].sv; snp_cmd = vq[i].sc;
         snp_idx = vq[i].si; dbg_idx = vq[i].di;
         #2;
         chk($sformatf("v%0d pr_ready", i), pr_ready, vq[i].rdy);
         chk($sformatf("v%0d bus_req", i), bus_req, vq[i].req);
         chk($sformatf("v%0d bus_cmd", i), bus_cmd, vq[i].cmd);
         chk($sformatf("v%0d bus_idx", i), bus_idx, vq[i].bi);
         chk($sformatf("v%0d snp_ready", i), snp_ready, vq[i].sr);
         chk($sformatf("v%0d snp_shared", i), snp_shared_out,
             vq[i].sso);
         chk($sformatf("v%0d snp_flush", i), snp_flush, vq[i].fl);
         chk($sformatf("v%0d dbg_state", i), dbg_state, vq[i].dst);
      end

      // test 6: MSI fill to S, then reset in the middle of a flush
      @(negedge clk);
      idle_in();
      rstb = 0;
      @(negedge clk);
      rstb = 1;
      @(negedge clk);
      pr_valid = 1; pr_idx = 0;
      @(negedge clk);
      bus_gnt = 1;
      #2;
      chk("msi bus_cmd", m_bus_cmd, RD);
      chk("mesi bus_cmd", bus_cmd, RD);
      @(negedge clk);
      bus_gnt = 0;
      #2;
      chk("msi pr_ready", m_pr_ready, 1);
      chk("msi line0", m_dbg_state, S);
      chk("mesi line0", dbg_state, E);
      @(negedge clk);
      pr_we = 1;
      @(negedge clk);
      pr_valid = 0; pr_we = 0;
      snp_valid = 1; snp_cmd = RD; snp_idx = 0;
      #2;
      chk("pre-flush line0", dbg_state, M);
      chk("pre-flush shared", snp_shared_out, 1);
      chk("msi upgr req", m_bus_req, 1);
      @(negedge clk);
      snp_valid = 0; snp_cmd = NONE;
      #2;
      chk("mid flush", snp_flush, 1);
      @(negedge clk);
      rstb = 0;
      #2;
      chk_reset("rst mid flush");
      chk("rst msi bus_req", m_bus_req, 0);
      for (int k = 0; k < 16; k++) begin
         dbg_idx = 4'(k);
         #1;
         chk($sformatf("rst line%0d", k), dbg_state, I);
         chk($sformatf("rst msi line%0d", k), m_dbg_state, I);
      end
      @(negedge clk);
      rstb = 1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
